tama_cmd_rx: RTL and testbench

TAMA_CMD_RX -- requirements
Module: tama_cmd_rx

---
 rtl/tama_pkg.sv | 30 +++
 rtl/tama_sync2.sv | 28 ++
 rtl/tama_cmd_rx.sv | 150 +++++++++++++++
 tb/tb_tama_cmd_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// Shared constants and FSM state type for the Tamagotchi-style UART command receiver.
package tama_pkg;

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_FEED  = 3'd1;
   localparam logic [2:0] CMD_PLAY  = 3'd2;
   localparam logic [2:0] CMD_CLEAN = 3'd3;
   localparam logic [2:0] CMD_SLEEP = 3'd4;
   localparam logic [2:0] CMD_TALK  = 3'd5;
   localparam logic [2:0] CMD_WAKE  = 3'd6;

   localparam logic [7:0] ASCII_F = 8'h46;
   localparam logic [7:0] ASCII_P = 8'h50;
   localparam logic [7:0] ASCII_C = 8'h43;
   localparam logic [7:0] ASCII_S = 8'h53;
   localparam logic [7:0] ASCII_T = 8'h54;
   localparam logic [7:0] ASCII_W = 8'h57;

   // Clearing bit 5 folds lower-case letters onto upper-case.
   localparam logic [7:0] CASE_MASK = 8'hDF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/tama_sync2.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
module tama_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic s1_q, s2_q, s3_q;

   // All stages reset high so a released reset on an idle line is quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rx_s = s2_q;
   assign fall = s3_q & ~s2_q;

endmodule

// File: rtl/tama_cmd_rx.sv
// 8N1 UART receiver that decodes single-letter care commands.
module tama_cmd_rx
   import tama_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   logic rx_s, fall;

   tama_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .rx_s  (rx_s),
      .fall  (fall)
   );

   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic [2:0]    cmd_q, cmd_d;
   logic          data_valid_q, data_valid_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [2:0]    dec;

   always_comb begin
      dec = CMD_NONE;
      case (shift_q & CASE_MASK)
         ASCII_F: dec = CMD_FEED;
         ASCII_P: dec = CMD_PLAY;
         ASCII_C: dec = CMD_CLEAN;
         ASCII_S: dec = CMD_SLEEP;
         ASCII_T: dec = CMD_TALK;
         ASCII_W: dec = CMD_WAKE;
         default: dec = CMD_NONE;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      data_d       = data_q;
      cmd_d        = cmd_q;
      data_valid_d = 1'b0;
      cmd_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d = ST_START;
               // The detect cycle is already one cycle into the start bit.
               cnt_d   = CW'(1);
               bit_d   = 3'd0;
            end
         end
         ST_START: begin
            if (cnt_q >= HALF_END) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d      = ST_IDLE;
                  data_d       = shift_q;
                  data_valid_d = 1'b1;
                  if (dec != CMD_NONE) begin
                     cmd_d       = dec;
                     cmd_valid_d = 1'b1;
                  end
               end else begin
                  state_d     = ST_WAIT_HIGH;
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= 3'd0;
         shift_q      <= 8'h00;
         data_q       <= 8'h00;
         cmd_q        <= CMD_NONE;
         data_valid_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         cmd_q        <= cmd_d;
         data_valid_q <= data_valid_d;
         cmd_valid_q  <= cmd_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign cmd        = cmd_q;
   assign cmd_valid  = cmd_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tama_cmd_rx.sv
// Scoreboard bench for tama_cmd_rx at 16 clocks per bit.
module tb_tama_cmd_rx;

   localparam int CPB    = 16;
   localparam int BIT_NS = 160;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       frame_err;
   logic       busy;

   tama_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       cv;
      logic [2:0] cmd;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   dv_cnt = 0;
   int   fe_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) fe_cnt++;
         if (data_valid) begin
            dv_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_dv got data=%h none expected", data);
            end else begin
               e = exp_q.pop_front();
               if (data !== e.data || cmd_valid !== e.cv || cmd !== e.cmd) begin
                  bad++;
                  $display("FAIL frame got data=%h cv=%b cmd=%0d want data=%h cv=%b cmd=%0d",
                           data, cmd_valid, cmd, e.data, e.cv, e.cmd);
               end
            end
         end else if (cmd_valid) begin
            total++;
            bad++;
            $display("FAIL cv_without_dv got cmd_valid=1 want 0");
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   task automatic push(input logic [7:0] d, input logic cv, input logic [2:0] c);
      exp_t x;
      x.data = d;
      x.cv   = cv;
      x.cmd  = c;
      exp_q.push_back(x);
   endtask

   task automatic send(input logic [7:0] b, input logic stop,
                       input logic idle_after, input int bit_ns);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop;
      #(bit_ns);
      rx = idle_after;
   endtask

   task automatic check_drained(input string name);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain got pending=%0d want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({data, cmd, data_valid, cmd_valid, frame_err, busy} !== 15'h0) begin
         bad++;
         $display("FAIL reset_state got data=%h cmd=%0d dv=%b cv=%b fe=%b busy=%b want 0",
                  data, cmd, data_valid, cmd_valid, frame_err, busy);
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      total++;
      if (busy !== 1'b0 || dv_cnt != 0) begin
         bad++;
         $display("FAIL reset_release got busy=%b dv=%0d want 0 0", busy, dv_cnt);
      end
   endtask

   task automatic test_feed();
      int dv0 = dv_cnt;
      push(8'h46, 1'b1, 3'd1);
      send(8'h46, 1'b1, 1'b1, BIT_NS);
      check_drained("feed");
      total++;
      if (dv_cnt - dv0 != 1 || data !== 8'h46 || cmd !== 3'd1) begin
         bad++;
         $display("FAIL feed got dv=%0d data=%h cmd=%0d want 1 46 1",
                  dv_cnt - dv0, data, cmd);
      end
   endtask

   task automatic test_back_to_back();
      int dv0 = dv_cnt;
      push(8'h70, 1'b1, 3'd2);
      push(8'h41, 1'b0, 3'd2);
      send(8'h70, 1'b1, 1'b1, BIT_NS);
      send(8'h41, 1'b1, 1'b1, BIT_NS);
      check_drained("b2b");
      total++;
      if (dv_cnt - dv0 != 2 || data !== 8'h41 || cmd !== 3'd2) begin
         bad++;
         $display("FAIL b2b got dv=%0d data=%h cmd=%0d want 2 41 2",
                  dv_cnt - dv0, data, cmd);
      end
   endtask

   task automatic test_frame_err();
      int dv0 = dv_cnt;
      int fe0 = fe_cnt;
      send(8'h53, 1'b0, 1'b0, BIT_NS);
      repeat (100) @(negedge clk);
      total++;
      if (busy !== 1'b1 || fe_cnt - fe0 != 1) begin
         bad++;
         $display("FAIL ferr_hold got busy=%b fe=%0d want 1 1", busy, fe_cnt - fe0);
      end
      total++;
      if (data !== 8'h41 || cmd !== 3'd2 || dv_cnt != dv0) begin
         bad++;
         $display("FAIL ferr_keep got data=%h cmd=%0d dv=%0d want 41 2 0",
                  data, cmd, dv_cnt - dv0);
      end
      rx = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (busy !== 1'b0 || fe_cnt - fe0 != 1) begin
         bad++;
         $display("FAIL ferr_release got busy=%b fe=%0d want 0 1", busy, fe_cnt - fe0);
      end
   endtask

   task automatic test_glitch();
      int dv0 = dv_cnt;
      int fe0 = fe_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL glitch_start got busy=%b want 1", busy);
      end
      repeat (30) @(negedge clk);
      total++;
      if (busy !== 1'b0 || dv_cnt != dv0 || fe_cnt != fe0) begin
         bad++;
         $display("FAIL glitch got busy=%b dv=%0d fe=%0d want 0 0 0",
                  busy, dv_cnt - dv0, fe_cnt - fe0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b = 8'h57;
      int dv0 = dv_cnt;
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = b[4];
      #(BIT_NS / 2);
      rst_n = 1'b0;
      #1;
      total++;
      if ({data, cmd, data_valid, cmd_valid, frame_err, busy} !== 15'h0) begin
         bad++;
         $display("FAIL reset_mid got data=%h cmd=%0d dv=%b cv=%b fe=%b busy=%b want 0",
                  data, cmd, data_valid, cmd_valid, frame_err, busy);
      end
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (dv_cnt != dv0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_abandon got dv=%0d busy=%b want 0 0", dv_cnt - dv0, busy);
      end
      push(8'h57, 1'b1, 3'd6);
      send(8'h57, 1'b1, 1'b1, BIT_NS);
      check_drained("wake");
      total++;
      if (cmd !== 3'd6) begin
         bad++;
         $display("FAIL wake got cmd=%0d want 6", cmd);
      end
   endtask

   task automatic test_case_fold();
      push(8'h74, 1'b1, 3'd5);
      push(8'h5A, 1'b0, 3'd5);
      send(8'h74, 1'b1, 1'b1, BIT_NS);
      send(8'h5A, 1'b1, 1'b1, BIT_NS);
      check_drained("fold");
   endtask

   task automatic test_tolerance();
      push(8'h43, 1'b1, 3'd3);
      send(8'h43, 1'b1, 1'b1, 165);
      repeat (5) @(negedge clk);
      push(8'h63, 1'b1, 3'd3);
      send(8'h63, 1'b1, 1'b1, 155);
      check_drained("tol");
      total++;
      if (data !== 8'h63 || cmd !== 3'd3) begin
         bad++;
         $display("FAIL tolerance got data=%h cmd=%0d want 63 3", data, cmd);
      end
   endtask

   initial begin
      test_reset();
      test_feed();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_case_fold();
      test_tolerance();
      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
